// File: rtl/bloom_pkg.sv
// Shared definitions for the bloom front-end dispatch/arbitration blocks.
package bloom_pkg;

   // Number of entries held by the dispatch skid buffer (main + skid).
   localparam int unsigned SKID_DEPTH = 2;

   // Index width needed to address n destinations; a single destination still gets one bit.
   function automatic int unsigned num_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/skid_buf.sv
// Generic two-entry valid/ready skid buffer: registered output (main) plus one overflow entry (skid).
module skid_buf #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] s_data_i,
   input  logic         s_valid_i,
   output logic         s_ready_o,
   output logic [W-1:0] m_data_o,
   output logic         m_valid_o,
   input  logic         m_ready_i
);

   logic [W-1:0] r_main_data;
   logic         r_main_valid;
   logic [W-1:0] r_skid_data;
   logic         r_skid_valid;
   logic         r_s_ready;

   logic [W-1:0] w_main_data;
   logic         w_main_valid;
   logic [W-1:0] w_skid_data;
   logic         w_skid_valid;
   logic         w_accept;
   logic         w_fire;

   // Next-state: refill main from skid first, else from the sink; overflow into skid when main is stuck.
   always_comb begin
      w_main_data  = r_main_data;
      w_main_valid = r_main_valid;
      w_skid_data  = r_skid_data;
      w_skid_valid = r_skid_valid;
      w_accept     = s_valid_i & r_s_ready;
      w_fire       = r_main_valid & m_ready_i;

      if (!r_main_valid || w_fire) begin
         if (r_skid_valid) begin
            w_main_data  = r_skid_data;
            w_main_valid = 1'b1;
            w_skid_valid = 1'b0;
         end else if (w_accept) begin
            w_main_data  = s_data_i;
            w_main_valid = 1'b1;
         end else begin
            w_main_valid = 1'b0;
         end
      end else if (w_accept) begin
         w_skid_data  = s_data_i;
         w_skid_valid = 1'b1;
      end
   end

   // State registers; sink ready is registered as "skid will be empty".
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_main_data  <= '0;
         r_main_valid <= 1'b0;
         r_skid_data  <= '0;
         r_skid_valid <= 1'b0;
         r_s_ready    <= 1'b1;
      end else begin
         r_main_data  <= w_main_data;
         r_main_valid <= w_main_valid;
         r_skid_data  <= w_skid_data;
         r_skid_valid <= w_skid_valid;
         r_s_ready    <= ~w_skid_valid;
      end
   end

   assign s_ready_o = r_s_ready;
   assign m_data_o  = r_main_data;
   assign m_valid_o = r_main_valid;

endmodule

// File: rtl/one_hot_dispatch.sv
// Steers each indexed word to one of REQ_NUM consumers via a one-hot valid vector.
// Out-of-range indices are accepted, dropped, and flagged with a one-cycle err_o pulse.
module one_hot_dispatch
   import bloom_pkg::*;
#(
   parameter int unsigned REQ_NUM   = 2,
   parameter int unsigned REQ_NUM_W = num_w(REQ_NUM),
   parameter int unsigned DATA_W    = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic [DATA_W-1:0]    snk_data_i,
   input  logic [REQ_NUM_W-1:0] snk_num_i,
   input  logic                 snk_valid_i,
   output logic                 snk_ready_o,
   output logic [DATA_W-1:0]    src_data_o,
   output logic [REQ_NUM-1:0]   src_valid_o,
   input  logic [REQ_NUM-1:0]   src_ready_i,
   output logic                 err_o
);

   localparam int unsigned ENTRY_W = DATA_W + REQ_NUM_W;

   typedef struct packed {
      logic [DATA_W-1:0]    data;
      logic [REQ_NUM_W-1:0] num;
   } entry_t;

   entry_t               w_snk_entry;
   entry_t               w_main_entry;
   logic [ENTRY_W-1:0]   w_main_bits;
   logic                 w_main_valid;
   logic                 w_bad;
   logic                 w_fire;
   logic [REQ_NUM-1:0]   w_onehot;
   logic                 r_err;

   // Range check: a single destination ignores the index entirely.
   generate
      if (REQ_NUM == 1) begin : g_single
         assign w_bad           = 1'b0;
         assign w_snk_entry.num = '0;
      end else begin : g_multi
         assign w_bad           = 32'(snk_num_i) >= 32'(REQ_NUM);
         assign w_snk_entry.num = snk_num_i;
      end
   endgenerate

   assign w_snk_entry.data = snk_data_i;

   skid_buf #(
      .W (ENTRY_W)
   ) u_skid_buf (
      .clk_i     (clk_i),
      .rst_n_i   (rst_n_i),
      .s_data_i  (w_snk_entry),
      .s_valid_i (snk_valid_i & ~w_bad),
      .s_ready_o (snk_ready_o),
      .m_data_o  (w_main_bits),
      .m_valid_o (w_main_valid),
      .m_ready_i (w_fire)
   );

   assign w_main_entry = entry_t'(w_main_bits);

   // One-hot decode of the registered destination index.
   always_comb begin
      w_onehot = '0;
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
         if (w_main_valid && (w_main_entry.num == REQ_NUM_W'(k))) begin
            w_onehot[k] = 1'b1;
         end
      end
   end

   assign w_fire = |(w_onehot & src_ready_i);

   // Error pulse for each accepted-and-dropped out-of-range word.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_err <= 1'b0;
      end else begin
         r_err <= snk_valid_i & snk_ready_o & w_bad;
      end
   end

   assign src_valid_o = w_onehot;
   assign src_data_o  = w_main_entry.data;
   assign err_o       = r_err;

endmodule

// File: tb/tb_one_hot_dispatch.sv
// Bench for one_hot_dispatch: directed scenarios on a 4-destination instance,
// out-of-range and randomized queue-model checks on a 3-destination instance.
module tb_one_hot_dispatch;

   logic clk;
   logic rst_n;

   // 4-destination instance
   logic [31:0] d4_data;
   logic [1:0]  d4_num;
   logic        d4_valid;
   logic        d4_rdy;
   logic [31:0] d4_sdata;
   logic [3:0]  d4_svalid;
   logic [3:0]  d4_sready;
   logic        d4_err;

   // 3-destination instance
   logic [31:0] d3_data;
   logic [1:0]  d3_num;
   logic        d3_valid;
   logic        d3_rdy;
   logic [31:0] d3_sdata;
   logic [2:0]  d3_svalid;
   logic [2:0]  d3_sready;
   logic        d3_err;

   int n_cmp;
   int n_err;

   one_hot_dispatch #(.REQ_NUM(4), .DATA_W(32)) u_dut4 (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .snk_data_i  (d4_data),
      .snk_num_i   (d4_num),
      .snk_valid_i (d4_valid),
      .snk_ready_o (d4_rdy),
      .src_data_o  (d4_sdata),
      .src_valid_o (d4_svalid),
      .src_ready_i (d4_sready),
      .err_o       (d4_err)
   );

   one_hot_dispatch #(.REQ_NUM(3), .DATA_W(32)) u_dut3 (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .snk_data_i  (d3_data),
      .snk_num_i   (d3_num),
      .snk_valid_i (d3_valid),
      .snk_ready_o (d3_rdy),
      .src_data_o  (d3_sdata),
      .src_valid_o (d3_svalid),
      .src_ready_i (d3_sready),
      .err_o       (d3_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      d4_data = '0; d4_num = '0; d4_valid = 1'b0; d4_sready = '0;
      d3_data = '0; d3_num = '0; d3_valid = 1'b0; d3_sready = '0;
      #12;
      n_cmp++;
      if (d4_svalid !== 4'b0000 || d4_sdata !== 32'h0 || d4_rdy !== 1'b1 || d4_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_d4: svalid=%b data=%h rdy=%b err=%b want 0000/0/1/0", d4_svalid, d4_sdata, d4_rdy, d4_err);
      end
      n_cmp++;
      if (d3_svalid !== 3'b000 || d3_sdata !== 32'h0 || d3_rdy !== 1'b1 || d3_err !== 1'b0) begin
         n_err++;
         $display("FAIL reset_d3: svalid=%b data=%h rdy=%b err=%b want 000/0/1/0", d3_svalid, d3_sdata, d3_rdy, d3_err);
      end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      d4_sready = 4'b0010;
      d4_data = 32'hA5A5_0001; d4_num = 2'd1; d4_valid = 1'b1;
      step();
      d4_valid = 1'b0;
      n_cmp++;
      if (d4_svalid !== 4'b0010 || d4_sdata !== 32'hA5A5_0001) begin
         n_err++;
         $display("FAIL single_out: svalid=%b data=%h want 0010/a5a50001", d4_svalid, d4_sdata);
      end
      n_cmp++;
      if (d4_err !== 1'b0) begin
         n_err++;
         $display("FAIL single_err: got %b want 0", d4_err);
      end
      step();
      n_cmp++;
      if (d4_svalid !== 4'b0000 || d4_err !== 1'b0) begin
         n_err++;
         $display("FAIL single_drain: svalid=%b err=%b want 0000/0", d4_svalid, d4_err);
      end
   endtask

   task automatic test_streaming();
      d4_sready = 4'b1111;
      for (int i = 0; i < 8; i++) begin
         d4_data = 32'h5000_0000 + 32'(i);
         d4_num  = 2'(i % 4);
         d4_valid = 1'b1;
         n_cmp++;
         if (d4_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL stream_rdy[%0d]: got %b want 1", i, d4_rdy);
         end
         step();
         n_cmp++;
         if (d4_svalid !== 4'(1 << (i % 4)) || d4_sdata !== 32'h5000_0000 + 32'(i)) begin
            n_err++;
            $display("FAIL stream_out[%0d]: svalid=%b data=%h want %b/%h", i, d4_svalid, d4_sdata,
                     4'(1 << (i % 4)), 32'h5000_0000 + 32'(i));
         end
      end
      d4_valid = 1'b0;
      step();
      n_cmp++;
      if (d4_svalid !== 4'b0000 || d4_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL stream_end: svalid=%b rdy=%b want 0000/1", d4_svalid, d4_rdy);
      end
   endtask

   task automatic test_backpressure();
      d4_sready = 4'b1011;
      d4_data = 32'hAAAA_0002; d4_num = 2'd2; d4_valid = 1'b1;
      step();
      d4_data = 32'hBBBB_0000; d4_num = 2'd0;
      n_cmp++;
      if (d4_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL bp_rdy_before_b: got %b want 1", d4_rdy);
      end
      step();
      d4_data = 32'hCCCC_0000; d4_num = 2'd0;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (d4_svalid !== 4'b0100 || d4_sdata !== 32'hAAAA_0002 || d4_rdy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold[%0d]: svalid=%b data=%h rdy=%b want 0100/aaaa0002/0", i, d4_svalid, d4_sdata, d4_rdy);
         end
         if (i < 3) step();
      end
      d4_sready = 4'b1111;
      step();
      n_cmp++;
      if (d4_svalid !== 4'b0001 || d4_sdata !== 32'hBBBB_0000 || d4_rdy !== 1'b1) begin
         n_err++;
         $display("FAIL bp_b: svalid=%b data=%h rdy=%b want 0001/bbbb0000/1", d4_svalid, d4_sdata, d4_rdy);
      end
      step();
      d4_valid = 1'b0;
      n_cmp++;
      if (d4_svalid !== 4'b0001 || d4_sdata !== 32'hCCCC_0000) begin
         n_err++;
         $display("FAIL bp_c: svalid=%b data=%h want 0001/cccc0000", d4_svalid, d4_sdata);
      end
      step();
      n_cmp++;
      if (d4_svalid !== 4'b0000) begin
         n_err++;
         $display("FAIL bp_end: svalid=%b want 0000", d4_svalid);
      end
   endtask

   task automatic test_wrong_ready();
      d4_sready = 4'b1101;
      d4_data = 32'h1234_5678; d4_num = 2'd1; d4_valid = 1'b1;
      step();
      d4_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (d4_svalid !== 4'b0010 || d4_sdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL wrong_rdy_hold[%0d]: svalid=%b data=%h want 0010/12345678", i, d4_svalid, d4_sdata);
         end
         step();
      end
      d4_sready = 4'b0010;
      step();
      n_cmp++;
      if (d4_svalid !== 4'b0000) begin
         n_err++;
         $display("FAIL wrong_rdy_release: svalid=%b want 0000", d4_svalid);
      end
   endtask

   task automatic test_mid_reset();
      d4_sready = 4'b0000;
      d4_data = 32'hDEAD_0003; d4_num = 2'd3; d4_valid = 1'b1;
      step();
      d4_data = 32'hBEEF_0000; d4_num = 2'd0;
      step();
      d4_valid = 1'b0;
      n_cmp++;
      if (d4_rdy !== 1'b0 || d4_svalid !== 4'b1000) begin
         n_err++;
         $display("FAIL mid_rst_full: rdy=%b svalid=%b want 0/1000", d4_rdy, d4_svalid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (d4_svalid !== 4'b0000 || d4_rdy !== 1'b1 || d4_sdata !== 32'h0) begin
         n_err++;
         $display("FAIL mid_rst_async: svalid=%b rdy=%b data=%h want 0000/1/0", d4_svalid, d4_rdy, d4_sdata);
      end
      @(negedge clk);
      rst_n = 1'b1;
      d4_sready = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         step();
         n_cmp++;
         if (d4_svalid !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_rst_lost[%0d]: svalid=%b want 0000", i, d4_svalid);
         end
      end
   endtask

   task automatic test_out_of_range();
      d3_sready = 3'b111;
      d3_data = 32'hBAD0_0001; d3_num = 2'd3; d3_valid = 1'b1;
      step();
      d3_data = 32'hBAD0_0002;
      n_cmp++;
      if (d3_err !== 1'b1 || d3_svalid !== 3'b000) begin
         n_err++;
         $display("FAIL oor_first: err=%b svalid=%b want 1/000", d3_err, d3_svalid);
      end
      step();
      d3_data = 32'h600D_0002; d3_num = 2'd2;
      n_cmp++;
      if (d3_err !== 1'b1 || d3_svalid !== 3'b000) begin
         n_err++;
         $display("FAIL oor_second: err=%b svalid=%b want 1/000", d3_err, d3_svalid);
      end
      step();
      d3_valid = 1'b0;
      n_cmp++;
      if (d3_err !== 1'b0 || d3_svalid !== 3'b100 || d3_sdata !== 32'h600D_0002) begin
         n_err++;
         $display("FAIL oor_good: err=%b svalid=%b data=%h want 0/100/600d0002", d3_err, d3_svalid, d3_sdata);
      end
      step();
      n_cmp++;
      if (d3_err !== 1'b0 || d3_svalid !== 3'b000) begin
         n_err++;
         $display("FAIL oor_end: err=%b svalid=%b want 0/000", d3_err, d3_svalid);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      int          num;
   } word_t;

   // Randomized traffic on the 3-destination instance against an in-order queue model.
   task automatic test_random();
      word_t q[$];
      word_t w;
      logic  exp_err;
      logic  exp_rdy;
      logic  acc;
      logic  fire;
      exp_err = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         d3_valid  = ($urandom_range(0, 9) < 7);
         d3_num    = 2'($urandom_range(0, 3));
         d3_data   = $urandom;
         d3_sready = 3'($urandom_range(0, 7));

         exp_rdy = (q.size() < 2);
         n_cmp++;
         if (d3_rdy !== exp_rdy) begin
            n_err++;
            $display("FAIL rand_rdy[%0d]: got %b want %b", cyc, d3_rdy, exp_rdy);
         end
         n_cmp++;
         if (d3_err !== exp_err) begin
            n_err++;
            $display("FAIL rand_err[%0d]: got %b want %b", cyc, d3_err, exp_err);
         end
         n_cmp++;
         if (q.size() > 0) begin
            if (d3_svalid !== 3'(1 << q[0].num) || d3_sdata !== q[0].data) begin
               n_err++;
               $display("FAIL rand_out[%0d]: svalid=%b data=%h want %b/%h", cyc, d3_svalid, d3_sdata,
                        3'(1 << q[0].num), q[0].data);
            end
         end else if (d3_svalid !== 3'b000) begin
            n_err++;
            $display("FAIL rand_idle[%0d]: svalid=%b want 000", cyc, d3_svalid);
         end

         acc  = d3_valid && exp_rdy;
         fire = (q.size() > 0) && d3_sready[q[0].num];
         if (fire) void'(q.pop_front());
         exp_err = acc && (int'(d3_num) >= 3);
         if (acc && int'(d3_num) < 3) begin
            w.data = d3_data;
            w.num  = int'(d3_num);
            q.push_back(w);
         end
         step();
      end
      d3_valid = 1'b0;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_single();
      test_streaming();
      test_backpressure();
      test_wrong_ready();
      test_mid_reset();
      test_out_of_range();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
